temp_conv_arbiter: RTL and testbench

- Shares one ROM-based temperature converter between two requesters.
- Arbitrates round-robin, range-checks each request, and drives the converter's input temperature and unit-select lines.
- Waits out the converter's fixed read latency, then returns the result with the requester ID on a valid/ready response channel.
- Sits between user-facing logic (switch/UART front ends) and the single converter instance.

---
 rtl/temp_conv_pkg.sv | 45 ++++
 rtl/temp_conv_arbiter_rr_arb2.sv | 42 ++++
 rtl/temp_conv_arbiter.sv | 161 ++++++++++++++++
 tb/tb_temp_conv_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temp_conv_pkg.sv
// temp_conv_pkg
// Shared types and constants for the temperature-converter arbiter:
//   - state_e    : arbiter FSM states (IDLE, LOOKUP, WAIT, RESP)
//   - UNIT_C/F   : unit-select encoding shared by requesters and converter
//   - *_DEF      : default legal input ranges (Celsius 0..100, Fahrenheit 32..212)
//   - in_range() : legality check of an input temperature for its unit
//   - clamp_temp(): pull an out-of-range input onto the nearest legal bound
package temp_conv_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_e;

  // 1 = input is Celsius (convert to F), 0 = input is Fahrenheit (convert to C)
  localparam logic UNIT_C = 1'b1;
  localparam logic UNIT_F = 1'b0;

  localparam logic [7:0] C_MIN_DEF = 8'd0;
  localparam logic [7:0] C_MAX_DEF = 8'd100;
  localparam logic [7:0] F_MIN_DEF = 8'd32;
  localparam logic [7:0] F_MAX_DEF = 8'd212;

  function automatic logic in_range(input logic [7:0] temp, input logic unit,
                                    input logic [7:0] c_min, input logic [7:0] c_max,
                                    input logic [7:0] f_min, input logic [7:0] f_max);
    if (unit == UNIT_C) return (temp >= c_min) && (temp <= c_max);
    else                return (temp >= f_min) && (temp <= f_max);
  endfunction

  function automatic logic [7:0] clamp_temp(input logic [7:0] temp, input logic unit,
                                            input logic [7:0] c_min, input logic [7:0] c_max,
                                            input logic [7:0] f_min, input logic [7:0] f_max);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = (unit == UNIT_C) ? c_min : f_min;
    hi = (unit == UNIT_C) ? c_max : f_max;
    if (temp < lo)      return lo;
    else if (temp > hi) return hi;
    else                return temp;
  endfunction

endpackage

// File: rtl/temp_conv_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin grant. A lone valid is always granted; with both valid
// the requester that was not granted last time wins. last_grant only moves
// when update_i signals that the current grant was actually taken.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (last_grant -> 1)
//   valid_i[1:0]: request lines, bit N = requester N
//   update_i   : current grant accepted; record its winner as last_grant
//   grant_o[1:0]: one-hot grant (0 when nothing is valid)
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned -- that is what keeps a latch from being inferred.
  always_comb begin
    grant_o = 2'b00;
    unique case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
    last_grant_d = update_i ? grant_o[1] : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first contested round.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge inputs, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/temp_conv_arbiter.sv
// temp_conv_arbiter
// Shares one ROM-based temperature converter between two requesters. A request
// is accepted in IDLE, range-checked, presented to the converter (LOOKUP), the
// converter's read latency is waited out (WAIT), and the result is returned
// with the requester id on a valid/ready response channel (RESP).
// Build option: TEMP_CONV_CLAMP_EN -- when defined, out-of-range inputs are
// clamped to the nearest legal bound and converted normally (resp_err = 1);
// when undefined they bypass the converter with resp_temp = 0, resp_err = 1.
// Ports:
//   CLK, RST                 : clock, asynchronous active-high reset
//   reqN_valid/ready/temp/unit: requester N channel (unit 1 = Celsius)
//   resp_valid/ready/temp/id/err: response channel
//   conv_temp, conv_unit     : registered converter inputs
//   conv_out                 : converter registered output
//   busy                     : FSM not in IDLE
module temp_conv_arbiter
  import temp_conv_pkg::*;
#(
  parameter logic [7:0] C_MIN   = C_MIN_DEF,
  parameter logic [7:0] C_MAX   = C_MAX_DEF,
  parameter logic [7:0] F_MIN   = F_MIN_DEF,
  parameter logic [7:0] F_MAX   = F_MAX_DEF,
  parameter int         ROM_LAT = 1  // converter read latency, must be >= 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_temp,
  input  logic       req0_unit,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_temp,
  input  logic       req1_unit,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_temp,
  output logic       resp_id,
  output logic       resp_err,
  output logic [7:0] conv_temp,
  output logic       conv_unit,
  input  logic [7:0] conv_out,
  output logic       busy
);

  localparam int                CNT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ROM_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       conv_temp_q, conv_temp_d;
  logic             conv_unit_q, conv_unit_d;
  logic [7:0]       resp_temp_q, resp_temp_d;
  logic             resp_id_q, resp_id_d;
  logic             resp_err_q, resp_err_d;

  logic [1:0] grant;
  logic       accept;
  logic [7:0] sel_temp;
  logic       sel_unit;
  logic       legal;

  // Grant is only honoured in IDLE; outside IDLE request inputs are ignored.
  assign accept   = (state_q == IDLE) && (req0_valid || req1_valid);
  assign sel_temp = grant[1] ? req1_temp : req0_temp;
  assign sel_unit = grant[1] ? req1_unit : req0_unit;
  assign legal    = in_range(sel_temp, sel_unit, C_MIN, C_MAX, F_MIN, F_MAX);

  rr_arb2 u_arb (
    .clk      (CLK),
    .rst      (RST),
    .valid_i  ({req1_valid, req0_valid}),
    .update_i (accept),
    .grant_o  (grant)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    conv_temp_d = conv_temp_q;
    conv_unit_d = conv_unit_q;
    resp_temp_d = resp_temp_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          resp_id_d = grant[1];
          if (legal) begin
            conv_temp_d = sel_temp;
            conv_unit_d = sel_unit;
            resp_err_d  = 1'b0;
            state_d     = LOOKUP;
          end else begin
`ifdef TEMP_CONV_CLAMP_EN
            // Convert the nearest legal value; resp_err flags the clamping.
            conv_temp_d = clamp_temp(sel_temp, sel_unit, C_MIN, C_MAX, F_MIN, F_MAX);
            conv_unit_d = sel_unit;
            resp_err_d  = 1'b1;
            state_d     = LOOKUP;
`else
            // Converter is left alone; answer immediately with an error.
            resp_temp_d = 8'd0;
            resp_err_d  = 1'b1;
            state_d     = RESP;
`endif
          end
        end
      end
      LOOKUP: begin
        // Converter samples conv_temp/conv_unit at the end of this cycle.
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          resp_temp_d = conv_out;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      conv_temp_q <= 8'd0;
      conv_unit_q <= 1'b0;
      resp_temp_q <= 8'd0;
      resp_id_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      conv_temp_q <= conv_temp_d;
      conv_unit_q <= conv_unit_d;
      resp_temp_q <= resp_temp_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
    end
  end

  assign req0_ready = (state_q == IDLE) && grant[0] && req0_valid;
  assign req1_ready = (state_q == IDLE) && grant[1] && req1_valid;
  assign resp_valid = (state_q == RESP);
  assign resp_temp  = resp_temp_q;
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign conv_temp  = conv_temp_q;
  assign conv_unit  = conv_unit_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_temp_conv_arbiter.sv
// Directed bench for temp_conv_arbiter. Two instances: dut (ROM_LAT = 1) and
// dut3 (ROM_LAT = 3), each wired to a behavioural converter ROM of matching
// latency (truncating integer conversion).
module tb_temp_conv_arbiter;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

`ifdef TEMP_CONV_CLAMP_EN
  localparam bit CLAMP   = 1'b1;
  localparam int ILL_LAT = 3;
`else
  localparam bit CLAMP   = 1'b0;
  localparam int ILL_LAT = 1;
`endif

  int errors = 0;
  int checks = 0;

  // ---------------- dut (ROM_LAT = 1) ----------------
  logic       req0_valid = 0, req1_valid = 0, resp_ready = 0;
  logic [7:0] req0_temp = 0, req1_temp = 0;
  logic       req0_unit = 0, req1_unit = 0;
  logic       req0_ready, req1_ready, resp_valid, resp_id, resp_err, conv_unit, busy;
  logic [7:0] resp_temp, conv_temp, conv_out;

  // ---------------- dut3 (ROM_LAT = 3) ----------------
  logic       b_req0_valid = 0, b_req1_valid = 0, b_resp_ready = 0;
  logic [7:0] b_req0_temp = 0, b_req1_temp = 0;
  logic       b_req0_unit = 0, b_req1_unit = 0;
  logic       b_req0_ready, b_req1_ready, b_resp_valid, b_resp_id, b_resp_err, b_conv_unit, b_busy;
  logic [7:0] b_resp_temp, b_conv_temp, b_conv_out, b_p0, b_p1;

  function automatic logic [7:0] conv_model(input logic [7:0] t, input logic u);
    int r;
    if (u) r = int'(t) * 9 / 5 + 32;
    else   r = (t < 8'd32) ? 0 : (int'(t) - 32) * 5 / 9;
    return r[7:0];
  endfunction

  always_ff @(posedge CLK) conv_out <= conv_model(conv_temp, conv_unit);

  always_ff @(posedge CLK) begin
    b_p0       <= conv_model(b_conv_temp, b_conv_unit);
    b_p1       <= b_p0;
    b_conv_out <= b_p1;
  end

  temp_conv_arbiter #(.ROM_LAT(1)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_temp(req0_temp), .req0_unit(req0_unit),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_temp(req1_temp), .req1_unit(req1_unit),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_temp(resp_temp),
    .resp_id(resp_id), .resp_err(resp_err),
    .conv_temp(conv_temp), .conv_unit(conv_unit), .conv_out(conv_out), .busy(busy)
  );

  temp_conv_arbiter #(.ROM_LAT(3)) dut3 (
    .CLK(CLK), .RST(RST),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_temp(b_req0_temp), .req0_unit(b_req0_unit),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_temp(b_req1_temp), .req1_unit(b_req1_unit),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_temp(b_resp_temp),
    .resp_id(b_resp_id), .resp_err(b_resp_err),
    .conv_temp(b_conv_temp), .conv_unit(b_conv_unit), .conv_out(b_conv_out), .busy(b_busy)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step();
    step();
    checks++;
    if ({resp_valid, resp_temp, resp_id, resp_err, conv_temp, conv_unit, busy, req0_ready, req1_ready} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b temp=%0d id=%b err=%b conv=%0d/%b busy=%b rdy=%b%b, need all 0",
               resp_valid, resp_temp, resp_id, resp_err, conv_temp, conv_unit, busy, req1_ready, req0_ready);
    end
    RST = 1'b0;
    step();
  endtask

  task automatic test_single_celsius();
    int n;
    resp_ready = 1'b1;
    req0_unit = 1'b1; req0_temp = 8'd100; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 10) begin step(); n++; end
    checks++;
    if (n != 0) begin errors++; $display("FAIL single_ready_delay: got %0d cycles, need 0", n); end
    step();
    req0_valid = 1'b0;
    checks++;
    if ({conv_temp, conv_unit, resp_valid, busy} !== {8'd100, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_lookup: got conv=%0d unit=%b valid=%b busy=%b, need 100 1 0 1", conv_temp, conv_unit, resp_valid, busy);
    end
    step();
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_wait_valid: got %b need 0", resp_valid); end
    step();
    checks++;
    if ({resp_valid, resp_temp, resp_id, resp_err} !== {1'b1, 8'd212, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_resp: got valid=%b temp=%0d id=%b err=%b, need 1 212 0 0", resp_valid, resp_temp, resp_id, resp_err);
    end
    step();
    checks++;
    if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_idle: got valid=%b busy=%b need 0 0", resp_valid, busy); end
  endtask

  // Issue one request on dut and check latency and response fields.
  task automatic run_one(input logic id, input logic unit, input logic [7:0] temp,
                         input logic [7:0] exp_temp, input logic exp_err, input int exp_lat,
                         input string name);
    int n;
    resp_ready = 1'b1;
    if (id) begin req1_unit = unit; req1_temp = temp; req1_valid = 1'b1; end
    else    begin req0_unit = unit; req0_temp = temp; req0_valid = 1'b1; end
    #1;
    n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin step(); n++; end
    checks++;
    if (n >= 10) begin
      errors++;
      $display("FAIL %s_accept: no ready within 10 cycles", name);
      req0_valid = 1'b0; req1_valid = 1'b0;
      return;
    end
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 12) begin step(); n++; end
    checks++;
    if (n != exp_lat) begin errors++; $display("FAIL %s_latency: got %0d need %0d", name, n, exp_lat); end
    checks++;
    if ({resp_temp, resp_id, resp_err} !== {exp_temp, id, exp_err}) begin
      errors++;
      $display("FAIL %s_resp: got temp=%0d id=%b err=%b, need %0d %b %b", name, resp_temp, resp_id, resp_err, exp_temp, id, exp_err);
    end
    step();
  endtask

  task automatic test_round_robin();
    int n;
    logic [1:0] exp_gnt;
    RST = 1'b1; step(); RST = 1'b0;
    resp_ready = 1'b1;
    req0_unit = 1'b1; req0_temp = 8'd0;  req0_valid = 1'b1;
    req1_unit = 1'b0; req1_temp = 8'd32; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      exp_gnt = (i % 2 == 1) ? 2'b10 : 2'b01;
      n = 0;
      while (!(req0_ready || req1_ready) && n < 10) begin step(); n++; end
      checks++;
      if ({req1_ready, req0_ready} !== exp_gnt) begin
        errors++;
        $display("FAIL rr_grant_%0d: got ready=%b%b need %b", i, req1_ready, req0_ready, exp_gnt);
      end
      step();
      n = 1;
      while (!resp_valid && n < 12) begin step(); n++; end
      checks++;
      if ({resp_valid, resp_id, resp_temp, resp_err} !== {1'b1, exp_gnt[1], (exp_gnt[1] ? 8'd0 : 8'd32), 1'b0}) begin
        errors++;
        $display("FAIL rr_resp_%0d: got valid=%b id=%b temp=%0d err=%b need id=%b temp=%0d",
                 i, resp_valid, resp_id, resp_temp, resp_err, exp_gnt[1], exp_gnt[1] ? 0 : 32);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_out_of_range();
    int n;
    // Last legal conversion was F 32 from requester 1.
    resp_ready = 1'b1;
    req0_unit = 1'b0; req0_temp = 8'd31; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 10) begin step(); n++; end
    step();
    req0_valid = 1'b0;
    checks++;
    if ({conv_temp, conv_unit} !== {8'd32, 1'b0}) begin
      errors++;
      $display("FAIL oor_conv_inputs: got %0d/%b need 32/0", conv_temp, conv_unit);
    end
    n = 1;
    while (!resp_valid && n < 12) begin step(); n++; end
    checks++;
    if (n != ILL_LAT) begin errors++; $display("FAIL oor_latency: got %0d need %0d", n, ILL_LAT); end
    checks++;
    if ({resp_temp, resp_err} !== {8'd0, 1'b1}) begin
      errors++;
      $display("FAIL oor_resp: got temp=%0d err=%b need 0 1", resp_temp, resp_err);
    end
    step();
    run_one(1'b1, 1'b1, 8'd101, CLAMP ? 8'd212 : 8'd0, 1'b1, ILL_LAT, "c_max_plus1");
    run_one(1'b0, 1'b0, 8'd213, CLAMP ? 8'd100 : 8'd0, 1'b1, ILL_LAT, "f_max_plus1");
    run_one(1'b1, 1'b1, 8'd255, CLAMP ? 8'd212 : 8'd0, 1'b1, ILL_LAT, "c_255");
    run_one(1'b0, 1'b0, 8'd0,   8'd0,                   1'b1, ILL_LAT, "f_zero");
    run_one(1'b0, 1'b0, 8'd212, 8'd100,                 1'b0, 3,       "f_max");
    run_one(1'b1, 1'b1, 8'd37,  8'd98,                  1'b0, 3,       "c_37");
    run_one(1'b1, 1'b0, 8'd98,  8'd36,                  1'b0, 3,       "f_98");
  endtask

  task automatic test_backpressure();
    int n;
    resp_ready = 1'b0;
    req0_unit = 1'b1; req0_temp = 8'd50; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 10) begin step(); n++; end
    step();
    // Both requesters now wait; requester 0 stays valid after being served.
    req1_unit = 1'b1; req1_temp = 8'd10; req1_valid = 1'b1;
    n = 1;
    while (!resp_valid && n < 12) begin step(); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({resp_valid, resp_temp, resp_id, busy, req0_ready, req1_ready} !== {1'b1, 8'd122, 1'b0, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b temp=%0d id=%b busy=%b rdy=%b%b need 1 122 0 1 00",
                 i, resp_valid, resp_temp, resp_id, busy, req1_ready, req0_ready);
      end
      step();
    end
    resp_ready = 1'b1;
    step();
    checks++;
    if ({resp_valid, busy, req1_ready, req0_ready} !== 4'b0010) begin
      errors++;
      $display("FAIL bp_release: got valid=%b busy=%b rdy=%b%b need 0 0 10", resp_valid, busy, req1_ready, req0_ready);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_in_wait();
    int n;
    logic seen;
    resp_ready = 1'b1;
    req0_unit = 1'b1; req0_temp = 8'd20; req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 10) begin step(); n++; end
    step();
    req0_valid = 1'b0;
    step();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_wait_busy: got %b need 1", busy); end
    RST = 1'b1;
    #1;
    checks++;
    if ({resp_valid, resp_temp, resp_id, resp_err, conv_temp, conv_unit, busy} !== 20'd0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got valid=%b temp=%0d id=%b err=%b conv=%0d/%b busy=%b, need all 0",
               resp_valid, resp_temp, resp_id, resp_err, conv_temp, conv_unit, busy);
    end
    step();
    RST = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (resp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_no_resp: got resp_valid after reset, need none"); end
    run_one(1'b0, 1'b1, 8'd20, 8'd68, 1'b0, 3, "after_rst");
  endtask

  task automatic test_rom_lat3();
    int n;
    b_resp_ready = 1'b1;
    b_req0_unit = 1'b1; b_req0_temp = 8'd37; b_req0_valid = 1'b1;
    #1;
    n = 0;
    while (!b_req0_ready && n < 10) begin step(); n++; end
    checks++;
    if (n >= 10) begin errors++; $display("FAIL lat3_accept: no ready within 10 cycles"); end
    step();
    b_req0_valid = 1'b0;
    n = 1;
    while (!b_resp_valid && n < 12) begin step(); n++; end
    checks++;
    if (n != 5) begin errors++; $display("FAIL lat3_latency: got %0d need 5", n); end
    checks++;
    if ({b_resp_temp, b_resp_id, b_resp_err} !== {8'd98, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL lat3_resp: got temp=%0d id=%b err=%b need 98 0 0", b_resp_temp, b_resp_id, b_resp_err);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_celsius();
    test_round_robin();
    test_out_of_range();
    test_backpressure();
    test_reset_in_wait();
    test_rom_lat3();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
